// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle, sign fixup on completion.
// Define MUL_DIV_FAST_MUL_EN for a single-cycle combinational multiplier.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            InValid,
    output logic            InReady,
    input  logic [XLEN-1:0] InA,
    input  logic [XLEN-1:0] InB,
    input  logic [2:0]      Op,
    input  logic            Kill,
    output logic            OutValid,
    input  logic            OutReady,
    output logic [XLEN-1:0] Result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [CW-1:0] LAST = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [2:0]      op_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] hi;
    logic [XLEN-1:0] lo;
    logic [XLEN-1:0] res_q;
    logic            neg_q;
    logic [CW-1:0]   cnt;

    logic            a_sgn;
    logic            b_sgn;
    logic            a_neg;
    logic            b_neg;
    logic            res_neg;
    logic            div_zero;
    logic            ovf;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic [XLEN-1:0] special;

    always_comb begin
        a_sgn    = (Op == 3'd1) || (Op == 3'd2) || (Op == 3'd4) || (Op == 3'd6);
        b_sgn    = (Op == 3'd1) || (Op == 3'd4) || (Op == 3'd6);
        a_neg    = a_sgn && InA[XLEN-1];
        b_neg    = b_sgn && InB[XLEN-1];
        a_mag    = a_neg ? -InA : InA;
        b_mag    = b_neg ? -InB : InB;
        // Remainder follows the dividend; everything else is the xor of signs
        res_neg  = (Op[2] && Op[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero = Op[2] && (InB == '0);
        ovf      = ((Op == 3'd4) || (Op == 3'd6)) &&
                   (InA == MIN_NEG) && (InB == '1);
        if (Op[1])
            special = div_zero ? InA : '0;
        else
            special = div_zero ? '1 : InA;
    end

    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   diff;
    logic            ge;
    logic [XLEN-1:0] hi_n;
    logic [XLEN-1:0] lo_n;

    // hi holds partial product / partial remainder, lo multiplier / quotient
    always_comb begin
        mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        shifted = {hi, lo[XLEN-1]};
        diff    = shifted - {1'b0, b_q};
        ge      = ~diff[XLEN];
        if (op_q[2]) begin
            hi_n = ge ? diff[XLEN-1:0] : shifted[XLEN-1:0];
            lo_n = {lo[XLEN-2:0], ge};
        end else begin
            hi_n = mul_sum[XLEN:1];
            lo_n = {mul_sum[0], lo[XLEN-1:1]};
        end
    end

    function automatic logic [XLEN-1:0] fixup(
        input logic [2:0]      op,
        input logic            neg,
        input logic [XLEN-1:0] h,
        input logic [XLEN-1:0] l
    );
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   d;
        p = neg ? -{h, l} : {h, l};
        d = op[1] ? h : l;
        if (op[2])
            fixup = neg ? -d : d;
        else if (op[1:0] == 2'd0)
            fixup = p[XLEN-1:0];
        else
            fixup = p[2*XLEN-1:XLEN];
    endfunction

`ifdef MUL_DIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_p;
    assign fast_p = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            res_q <= '0;
            op_q  <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
            neg_q <= 1'b0;
            cnt   <= '0;
        end else if (Kill && (state != IDLE)) begin
            state <= IDLE;
            res_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (InValid && !Kill) begin
                        op_q  <= Op;
                        b_q   <= b_mag;
                        neg_q <= res_neg;
                        cnt   <= '0;
                        hi    <= '0;
                        lo    <= a_mag;
                        if (div_zero || ovf) begin
                            state <= DONE;
                            res_q <= special;
`ifdef MUL_DIV_FAST_MUL_EN
                        end else if (!Op[2]) begin
                            state <= DONE;
                            res_q <= fixup(Op, res_neg, fast_p[2*XLEN-1:XLEN],
                                           fast_p[XLEN-1:0]);
`endif
                        end else begin
                            state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    hi  <= hi_n;
                    lo  <= lo_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        res_q <= fixup(op_q, neg_q, hi_n, lo_n);
                    end
                end
                DONE: begin
                    if (OutReady) begin
                        state <= IDLE;
                        res_q <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    res_q <= '0;
                end
            endcase
        end
    end

    assign InReady  = (state == IDLE) && !rst;
    assign OutValid = (state == DONE);
    assign Result   = res_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed RV32M corners plus random ops
// checked against an arithmetic reference model, with latency checks.
module tb_mul_div_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        InValid = 1'b0;
    logic        InReady;
    logic [31:0] InA = '0;
    logic [31:0] InB = '0;
    logic [2:0]  Op = '0;
    logic        Kill = 1'b0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] Result;

    mul_div_unit #(.XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .InValid(InValid), .InReady(InReady),
        .InA(InA), .InB(InB), .Op(Op), .Kill(Kill),
        .OutValid(OutValid), .OutReady(OutReady), .Result(Result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        logic [31:0] res;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   hold_cycles = 0;
    bit   active = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        longint      sa, sb_, ub;
        logic [63:0] p;
        bit          ov;
        sa  = longint'(signed'(a));
        sb_ = longint'(signed'(b));
        ub  = longint'({32'b0, b});
        ov  = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (op)
            3'd0: begin p = 64'(sa * sb_); return p[31:0]; end
            3'd1: begin p = 64'(sa * sb_); return p[63:32]; end
            3'd2: begin p = 64'(sa * ub); return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ov) return a;
                return 32'(sa / sb_);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ov) return 32'h0;
                return 32'(sa % sb_);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] op, input logic [31:0] a,
                               input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 &&
            b == 32'hFFFF_FFFF) return 1;
`ifdef MUL_DIV_FAST_MUL_EN
        if (!op[2]) return 1;
`endif
        return 33;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp);
        int   n = 0;
        exp_t e;
        @(negedge clk);
        while (!InReady && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!InReady) begin
            chk("accept_timeout", 64'(InReady), 64'd1);
        end else begin
            InValid = 1'b1;
            Op = op;
            InA = a;
            InB = b;
            e.res = exp;
            e.acc = cyc + 1;
            e.lat = lat(op, a, b);
            sb.push_back(e);
            @(negedge clk);
            InValid = 1'b0;
            InA = $urandom;
            InB = $urandom;
            Op = 3'($urandom);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || active) && n < 1000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 64'(sb.size()), 64'd0);
    endtask

    initial begin : monitor
        bit          post_hs = 0;
        int          wait_n = 0;
        logic [31:0] held = '0;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (rst) begin
                active = 0;
                post_hs = 0;
                OutReady = 1'b0;
            end else begin
                if (post_hs) begin
                    chk("idle_after_hs", 64'(InReady), 64'd1);
                    post_hs = 0;
                end
                if (OutValid) begin
                    if (!active) begin
                        active = 1;
                        wait_n = 0;
                        held = Result;
                        if (sb.size() == 0) begin
                            chk("unexpected_out", 64'(OutValid), 64'd0);
                        end else begin
                            e = sb.pop_front();
                            chk("result", 64'(Result), 64'(e.res));
                            chk("latency", 64'(cyc + 1 - e.acc), 64'(e.lat));
                        end
                    end else begin
                        chk("result_stable", 64'(Result), 64'(held));
                    end
                    chk("inready_done", 64'(InReady), 64'd0);
                    if (wait_n < hold_cycles)
                        OutReady = 1'b0;
                    else
                        OutReady = (hold_cycles != 0) ||
                                   ($urandom_range(0, 3) != 0);
                    wait_n++;
                    if (OutReady && !Kill) begin
                        active = 0;
                        post_hs = 1;
                    end
                end else begin
                    chk("result_zero", 64'(Result), 64'd0);
                    OutReady = 1'(($urandom_range(0, 1)));
                end
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    localparam int ND = 15;
    logic [2:0]  d_op [ND] = '{3'd0, 3'd3, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4,
                                3'd6, 3'd4, 3'd6, 3'd1, 3'd2, 3'd0, 3'd5,
                                3'd7};
    logic [31:0] d_a  [ND] = '{32'd15, 32'hFFFF_FFFF, 32'hFFFF_FFF9,
                                32'hFFFF_FFF9, 32'd25, 32'd25, 32'd5, 32'd5,
                                32'h8000_0000, 32'h8000_0000, 32'h8000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd7, 32'd7};
    logic [31:0] d_b  [ND] = '{32'd10, 32'hFFFF_FFFF, 32'd2, 32'd2, 32'd10,
                                32'd10, 32'd0, 32'd0, 32'hFFFF_FFFF,
                                32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                                32'd5, 32'd0, 32'd0};
    logic [31:0] d_r  [ND] = '{32'd150, 32'hFFFF_FFFE, 32'hFFFF_FFFD,
                                32'hFFFF_FFFF, 32'd2, 32'd5, 32'hFFFF_FFFF,
                                32'd5, 32'h8000_0000, 32'd0, 32'h4000_0000,
                                32'hFFFF_FFFF, 32'hFFFF_FFF1, 32'hFFFF_FFFF,
                                32'd7};

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin : driver
        logic [2:0]  op;
        logic [31:0] a, b;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_inready", 64'(InReady), 64'd0);
        chk("rst_outvalid", 64'(OutValid), 64'd0);
        chk("rst_result", 64'(Result), 64'd0);
        rst = 1'b0;
        #1;
        chk("inready_after_rst", 64'(InReady), 64'd1);

        for (int i = 0; i < ND; i++) begin
            issue(d_op[i], d_a[i], d_b[i], d_r[i]);
            wait_idle();
        end

        hold_cycles = 5;
        issue(3'd5, 32'd25, 32'd10, 32'd2);
        wait_idle();
        hold_cycles = 5;
        issue(3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
        wait_idle();
        hold_cycles = 0;

        @(negedge clk);
        InValid = 1'b1;
        Kill = 1'b1;
        Op = 3'd4;
        InA = 32'd5;
        InB = 32'd0;
        @(negedge clk);
        InValid = 1'b0;
        Kill = 1'b0;
        chk("kill_idle_block", 64'(InReady), 64'd1);

        issue(3'd5, 32'd1000, 32'd7, 32'd142);
        repeat (9) @(negedge clk);
        Kill = 1'b1;
        void'(sb.pop_back());
        @(negedge clk);
        Kill = 1'b0;
        chk("kill_to_idle", 64'(InReady), 64'd1);
        chk("kill_no_out", 64'(OutValid), 64'd0);

        issue(3'd4, 32'd100, 32'd3, 32'd33);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        void'(sb.pop_back());
        #1;
        chk("rst_busy_inready", 64'(InReady), 64'd0);
        @(negedge clk);
        chk("rst_busy_outvalid", 64'(OutValid), 64'd0);
        rst = 1'b0;
        #1;
        chk("rst_busy_release", 64'(InReady), 64'd1);
        repeat (40) @(negedge clk);
        issue(3'd0, 32'd3, 32'd4, 32'd12);
        wait_idle();

        for (int i = 0; i < 150; i++) begin
            op = 3'($urandom);
            a = pick();
            b = pick();
            issue(op, a, b, model(op, a, b));
            wait_idle();
        end

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
